// File: rtl/cache_pkg.sv
// cache_pkg: shared types for the cache line-fetch path.
// Fetch commands, requester owner codes and arbiter FSM states.
package cache_pkg;

  typedef enum logic [1:0] {
    FETCH_WB   = 2'b00,
    FETCH_LINE = 2'b01
  } fetch_cmd_t;

  localparam logic OWN_RD = 1'b0;
  localparam logic OWN_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } fetch_arb_state_t;

endpackage

// File: rtl/fetch_arb_pick.sv
// fetch_arb_pick: combinational winner select for the fetch arbiter.
// in: rd/wr request, last granted owner; out: any-request, winner.
module fetch_arb_pick
  import cache_pkg::*;
#(
  parameter int prio_mode = 0
) (
  input  logic i_rd_req,
  input  logic i_wr_req,
  input  logic i_last_grant,
  output logic o_valid,
  output logic o_owner
);

  always_comb begin
    o_valid = i_rd_req | i_wr_req;
    o_owner = OWN_RD;
    unique case (1'b1)
      (i_rd_req && i_wr_req): begin
        // tie: fixed mode favours rd, else the side not served last
        if (prio_mode == 1) o_owner = OWN_RD;
        else                o_owner = ~i_last_grant;
      end
      (!i_rd_req && i_wr_req): o_owner = OWN_WR;
      default:                 o_owner = OWN_RD;
    endcase
  end

endmodule

// File: rtl/fetch_arb.sv
// fetch_arb: shares the line-fetch engine between the cache read and
// write controllers. Latches one command, forwards it to the engine,
// routes gnt/done back to the owner, counts completions per side.
// Ports: clk/rst_n; rd_fetch_*/wr_fetch_* requester sides;
// eng_* engine side; arb_busy/arb_owner status; *_fetch_cnt debug.
module fetch_arb
  import cache_pkg::*;
#(
  parameter int addr_width = 32,
  parameter int list_depth = 4,
  parameter int prio_mode  = 0,
  parameter int cnt_width  = 16,
  localparam int TW = $clog2(list_depth)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_fetch_req,
  input  logic [1:0]            rd_fetch_cmd,
  input  logic [TW-1:0]         rd_fetch_tag,
  input  logic [addr_width-1:0] rd_fetch_addr,
  output logic                  rd_fetch_gnt,
  output logic                  rd_fetch_done,
  input  logic                  wr_fetch_req,
  input  logic [1:0]            wr_fetch_cmd,
  input  logic [TW-1:0]         wr_fetch_tag,
  input  logic [addr_width-1:0] wr_fetch_addr,
  output logic                  wr_fetch_gnt,
  output logic                  wr_fetch_done,
  output logic                  eng_req,
  output logic [1:0]            eng_cmd,
  output logic [TW-1:0]         eng_tag,
  output logic [addr_width-1:0] eng_addr,
  input  logic                  eng_gnt,
  input  logic                  eng_done,
  output logic                  arb_busy,
  output logic                  arb_owner,
  output logic [cnt_width-1:0]  rd_fetch_cnt,
  output logic [cnt_width-1:0]  wr_fetch_cnt
);

  fetch_arb_state_t r_state;
  fetch_arb_state_t w_state_nxt;

  logic                  r_owner;
  logic                  r_last_grant;
  logic [1:0]            r_cmd;
  logic [TW-1:0]         r_tag;
  logic [addr_width-1:0] r_addr;
  logic [cnt_width-1:0]  r_rd_cnt;
  logic [cnt_width-1:0]  r_wr_cnt;

  logic                  w_pick_valid;
  logic                  w_pick_owner;
  logic                  w_latch;
  logic                  w_gnt;
  logic                  w_done;
  logic                  w_eng_req;
  logic [1:0]            w_sel_cmd;
  logic [TW-1:0]         w_sel_tag;
  logic [addr_width-1:0] w_sel_addr;
  logic                  w_owner_req;

  fetch_arb_pick #(
    .prio_mode (prio_mode)
  ) u_pick (
    .i_rd_req     (rd_fetch_req),
    .i_wr_req     (wr_fetch_req),
    .i_last_grant (r_last_grant),
    .o_valid      (w_pick_valid),
    .o_owner      (w_pick_owner)
  );

  always_comb begin
    if (w_pick_owner == OWN_WR) begin
      w_sel_cmd  = wr_fetch_cmd;
      w_sel_tag  = wr_fetch_tag;
      w_sel_addr = wr_fetch_addr;
    end else begin
      w_sel_cmd  = rd_fetch_cmd;
      w_sel_tag  = rd_fetch_tag;
      w_sel_addr = rd_fetch_addr;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_gnt       = 1'b0;
    w_done      = 1'b0;
    w_eng_req   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_latch     = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_eng_req = 1'b1;
        if (eng_gnt) begin
          w_gnt = 1'b1;
          // engine may finish in the accept cycle
          w_done = eng_done;
          w_state_nxt = eng_done ? IDLE : WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (eng_done) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_owner      <= OWN_RD;
      r_last_grant <= OWN_WR;
      r_cmd        <= '0;
      r_tag        <= '0;
      r_addr       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_owner <= w_pick_owner;
        r_cmd   <= w_sel_cmd;
        r_tag   <= w_sel_tag;
        r_addr  <= w_sel_addr;
      end
      if (w_gnt) r_last_grant <= r_owner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_done) begin
      if (r_owner == OWN_RD) begin
        if (r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + cnt_width'(1);
      end else begin
        if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + cnt_width'(1);
      end
    end
  end

  assign rd_fetch_gnt  = w_gnt  & (r_owner == OWN_RD);
  assign wr_fetch_gnt  = w_gnt  & (r_owner == OWN_WR);
  assign rd_fetch_done = w_done & (r_owner == OWN_RD);
  assign wr_fetch_done = w_done & (r_owner == OWN_WR);

  assign eng_req   = w_eng_req;
  assign eng_cmd   = r_cmd;
  assign eng_tag   = r_tag;
  assign eng_addr  = r_addr;
  assign arb_busy  = (r_state != IDLE);
  assign arb_owner = r_owner;

  assign rd_fetch_cnt = r_rd_cnt;
  assign wr_fetch_cnt = r_wr_cnt;

  // the owner must keep its request up until the engine accepts
  assign w_owner_req = (r_owner == OWN_WR) ? wr_fetch_req : rd_fetch_req;

  a_req_held: assert property (
    @(posedge clk) disable iff (!rst_n)
    (r_state == ISSUE) |-> w_owner_req
  );

endmodule
